debug_unit_ctrl: RTL and testbench
==================================

# debug_unit_ctrl

Host-facing debug controller for the MIPS pipeline. It sits between a byte-stream link (UART RX/TX wrapper) and the pipeline's debug ports. It loads instruction memory byte by byte and runs the program in continuous or single-step mode. On halt or step it streams back the last PC, a cycle count, the whole register bank and the data memory.

## Interface
- NB_PC, 32, PC width (multiple of 8)
- NB_DATA, 32, register-bank word width (multiple of 8)
- NB_REG, 5, register address width
- N_REGS, 32, registers dumped
- NB_ADDR, 32, instruction-memory address width
- MAX_INSTR_BYTES, 256, instruction-memory capacity in bytes
- NB_MEM_ADDR, 7, data-memory address width
- N_MEM_BYTES, 128, data-memory bytes dumped
- NB_CYCLES, 32, cycle counter width (multiple of 8)

Ports:
- i_clock  in  1  single clock; all logic rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  8  host byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_tx_data  out  8  byte to host
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  TX accepts byte
- o_pc_enable  out  1  pipeline advance
- o_pc_reset  out  1  PC reset
- o_pipeline_reset  out  1  ID / forward-stall reset
- o_instru_mem_write_enable  out  1  one-cycle instruction byte write
- o_instru_mem_addr  out  NB_ADDR  write address
- o_instru_mem_data  out  8  write byte
- o_bank_register_read_enable  out  1  register read strobe
- o_bank_register_addr  out  NB_REG  register address
- i_bank_register_data  in  NB_DATA  register data, valid 1 cycle after strobe
- o_mem_data_read_enable  out  1  data-memory read strobe
- o_mem_data_read_addr  out  NB_MEM_ADDR  byte address
- i_mem_data_data  in  8  data byte, valid 1 cycle after strobe
- i_halt  in  1  pipeline executed HALT
- i_last_pc  in  NB_PC  PC of last retired instruction
- o_state  out  4  FSM state code (debug)

## Operation
- States:
  - IDLE=0
  - LEN_HI=1
  - LEN_LO=2
  - LOAD=3
  - ACK=4
  - PRE_RUN=5
  - RUN=6
  - STEP=7
  - DUMP_PC=8
  - DUMP_CYC=9
  - DUMP_REG=10
  - DUMP_MEM=11
- Reset values:
  - o_pc_reset=1, o_pipeline_reset=1.
  - All other outputs 0; o_state=IDLE.
  - Cycle counter=0, fresh flag=1.
- IDLE command bytes:
  - 0x4C 'L' → LEN_HI.
  - 0x43 'C' → PRE_RUN.
  - 0x53 'S' → STEP, or PRE_RUN if fresh.
  - 0x44 'D' → DUMP_PC without running.
  - Any other byte: ignored.
- Load:
  - LEN_HI and LEN_LO capture a 16-bit big-endian length N.
  - Entering LEN_HI sets o_pc_reset=o_pipeline_reset=1 and fresh=1.
  - N=0 → ACK directly.
  - LOAD: byte k (k=0..N-1) pulses write_enable for one cycle with addr=k, data=byte.
  - Bytes with k≥MAX_INSTR_BYTES are consumed but not written.
  - After byte N-1 → ACK.
  - ACK sends 0x4C, then → IDLE.
- PRE_RUN: lasts one cycle with both resets=1; clears the cycle counter and fresh; then → RUN ('C') or STEP ('S').
- RUN:
  - Resets=0, o_pc_enable=1; the counter increments every cycle o_pc_enable=1.
  - When i_halt=1 is sampled, o_pc_enable drops on the next edge → DUMP_PC.
  - RX bytes are dropped.
- STEP:
  - If i_halt=0: exactly one cycle of o_pc_enable=1, counter +1.
  - If i_halt=1: no pulse.
  - Then → DUMP_PC.
- Dump:
  - Order: PC, NB_PC/8 bytes MSB first. Counter, NB_CYCLES/8 bytes MSB first. Registers 0..N_REGS-1, NB_DATA/8 bytes each MSB first. Data memory 0..N_MEM_BYTES-1.
  - Each word is fetched with a one-cycle read strobe, captured on the following cycle into a shift register, then shifted out.
  - After the last byte → IDLE with resets kept at 0, so pipeline state is preserved for further steps.
- TX handshake:
  - o_tx_data is stable and o_tx_valid held until a cycle with i_tx_ready=1.
  - The next byte may be valid on the cycle after a transfer.

## Timing
- Instruction write: the write pulse occurs in the cycle after the i_rx_valid edge that captured the byte.
- PRE_RUN: exactly 1 cycle.
- Halt response: o_pc_enable=0 one cycle after i_halt is first sampled high.
- Register / data-memory read: strobe at cycle t, data captured at t+1, first byte valid at t+2.
- Minimum dump length with ready tied high: (NB_PC+NB_CYCLES)/8 + N_REGS·(NB_DATA/8 + 2) + 3·N_MEM_BYTES cycles.
- i_reset=1 mid-operation: next edge returns to IDLE with reset values.
  - o_tx_valid drops immediately, even mid-byte.
  - A load in progress is abandoned.
- Counter saturates at all-ones; it does not wrap.
- Simultaneous i_halt with the PRE_RUN cycle: the halt is ignored, because the pipeline is in reset.

## Configuration
- STEP_MODE_EN defined: 'S' command and STEP state are present.
- STEP_MODE_EN undefined:
  - 0x53 is treated as an unknown command and ignored.
  - STEP state is not synthesised; the fresh flag is unused.

## Test plan
- Load: 'L', 0x00, 0x04, then 0xDE 0xAD 0xBE 0xEF → write pulses at addr 0..3 carrying those bytes; then tx byte 0x4C; o_pc_reset remains 1.
- Run: load a program whose HALT retires at PC=0x14, then 'C' → o_pc_enable high until the cycle after i_halt. Dump begins with 0x00 0x00 0x00 0x14, followed by the cycle count, then 32×4 register bytes and 128 memory bytes.
- TX backpressure: hold i_tx_ready=0 for 10 cycles mid-dump → o_tx_data stable and no byte lost; total byte count still 4+4+128+128.
- Step (STEP_MODE_EN): after load, send 'S' three times → PRE_RUN once, three single-cycle enable pulses, three dumps with counters 1, 2, 3.
- Oversize load: length 0x0101 with MAX_INSTR_BYTES=256 → 256 writes; the 257th byte produces no write; ACK 0x4C.
- Reset mid-RUN: assert i_reset → next cycle o_pc_enable=0, o_pc_reset=1, o_tx_valid=0, o_state=0; a following 'D' dumps a counter of 0.

Source files
------------

// File: rtl/debug_unit_ctrl_if.sv
// Host byte-stream link between the UART wrapper and debug_unit_ctrl.
// The master side is the link (drives RX bytes, TX ready).
// The slave side is the debug controller.
interface debug_unit_ctrl_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (output i_rx_data, i_rx_valid, i_tx_ready,
                  input  o_tx_data, o_tx_valid);
  modport slave  (input  i_rx_data, i_rx_valid, i_tx_ready,
                  output o_tx_data, o_tx_valid);
endinterface

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: host-facing debug controller for the MIPS pipeline.
// It loads instruction memory from the byte stream and runs the program
// continuously or stepwise. After a halt or step it dumps, in order:
// PC, cycle count, register bank, data memory.
// Optional macro: STEP_MODE_EN adds the 'S' command and the STEP state.
module debug_unit_ctrl #(
  parameter int NB_PC           = 32,
  parameter int NB_DATA         = 32,
  parameter int NB_REG          = 5,
  parameter int N_REGS          = 32,
  parameter int NB_ADDR         = 32,
  parameter int MAX_INSTR_BYTES = 256,
  parameter int NB_MEM_ADDR     = 7,
  parameter int N_MEM_BYTES     = 128,
  parameter int NB_CYCLES       = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  debug_unit_ctrl_if.slave       host,
  output logic                   o_pc_enable,
  output logic                   o_pc_reset,
  output logic                   o_pipeline_reset,
  output logic                   o_instru_mem_write_enable,
  output logic [NB_ADDR-1:0]     o_instru_mem_addr,
  output logic [7:0]             o_instru_mem_data,
  output logic                   o_bank_register_read_enable,
  output logic [NB_REG-1:0]      o_bank_register_addr,
  input  logic [NB_DATA-1:0]     i_bank_register_data,
  output logic                   o_mem_data_read_enable,
  output logic [NB_MEM_ADDR-1:0] o_mem_data_read_addr,
  input  logic [7:0]             i_mem_data_data,
  input  logic                   i_halt,
  input  logic [NB_PC-1:0]       i_last_pc,
  output logic [3:0]             o_state
);
  // Shift register wide enough for the widest dumped word.
  localparam int NB_SH0 = (NB_PC > NB_CYCLES) ? NB_PC : NB_CYCLES;
  localparam int NB_SH  = (NB_SH0 > NB_DATA) ? NB_SH0 : NB_DATA;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_LEN_HI = 4'd1, ST_LEN_LO = 4'd2, ST_LOAD = 4'd3,
    ST_ACK = 4'd4, ST_PRE_RUN = 4'd5, ST_RUN = 4'd6, ST_STEP = 4'd7,
    ST_DUMP_PC = 4'd8, ST_DUMP_CYC = 4'd9, ST_DUMP_REG = 4'd10,
    ST_DUMP_MEM = 4'd11
  } state_t;

  state_t                 r_state;
  logic [15:0]            r_len, r_cnt, r_idx;
  logic [7:0]             r_left;   // bytes of the current word still to present
  logic [1:0]             r_phase;  // 0 strobe, 1 capture, 2 shift out
  logic [NB_SH-1:0]       r_shift;
  logic [NB_CYCLES-1:0]   r_cycles;
  logic                   r_tx_valid;
  logic [7:0]             r_tx_data;
  logic                   r_pc_enable, r_pc_reset, r_pipe_reset;
  logic                   r_im_we;
  logic [NB_ADDR-1:0]     r_im_addr;
  logic [7:0]             r_im_data;
  logic                   r_reg_re;
  logic [NB_REG-1:0]      r_reg_addr;
  logic                   r_mem_re;
  logic [NB_MEM_ADDR-1:0] r_mem_addr;
`ifdef STEP_MODE_EN
  logic                   r_fresh;     // no run since the last load or reset
  logic                   r_go_step;   // PRE_RUN continues into STEP
  logic                   r_step_done; // the single enable pulse was issued
`endif

  logic [15:0]      w_len;
  logic             w_slot;
  logic [NB_SH-1:0] w_pc_al, w_cyc_al, w_reg_al;

  assign w_len    = {r_len[15:8], host.i_rx_data};
  // TX slot free: nothing pending, or the pending byte transfers this edge.
  assign w_slot   = !r_tx_valid || host.i_tx_ready;
  assign w_pc_al  = NB_SH'(i_last_pc) << (NB_SH - NB_PC);
  assign w_cyc_al = NB_SH'(r_cycles) << (NB_SH - NB_CYCLES);
  assign w_reg_al = NB_SH'(i_bank_register_data) << (NB_SH - NB_DATA);

  // Control FSM; every output is a register updated here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_left       <= '0;
      r_phase      <= '0;
      r_shift      <= '0;
      r_cycles     <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_pc_enable  <= 1'b0;
      r_pc_reset   <= 1'b1;
      r_pipe_reset <= 1'b1;
      r_im_we      <= 1'b0;
      r_im_addr    <= '0;
      r_im_data    <= '0;
      r_reg_re     <= 1'b0;
      r_reg_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= '0;
`ifdef STEP_MODE_EN
      r_fresh      <= 1'b1;
      r_go_step    <= 1'b0;
      r_step_done  <= 1'b0;
`endif
    end else begin
      r_im_we <= 1'b0;
      // Saturating count of cycles in which the pipeline advanced.
      if (r_pc_enable && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;

      case (r_state)
        ST_IDLE: if (host.i_rx_valid) begin
          case (host.i_rx_data)
            8'h4C: begin
              r_state      <= ST_LEN_HI;
              r_pc_reset   <= 1'b1;
              r_pipe_reset <= 1'b1;
`ifdef STEP_MODE_EN
              r_fresh      <= 1'b1;
`endif
            end
            8'h43: begin
              r_state      <= ST_PRE_RUN;
              r_pc_reset   <= 1'b1;
              r_pipe_reset <= 1'b1;
`ifdef STEP_MODE_EN
              r_go_step    <= 1'b0;
`endif
            end
`ifdef STEP_MODE_EN
            8'h53: begin
              if (r_fresh) begin
                r_state      <= ST_PRE_RUN;
                r_pc_reset   <= 1'b1;
                r_pipe_reset <= 1'b1;
                r_go_step    <= 1'b1;
              end else begin
                r_state     <= ST_STEP;
                r_step_done <= 1'b0;
              end
            end
`endif
            8'h44: begin
              r_state    <= ST_DUMP_PC;
              r_tx_data  <= i_last_pc[NB_PC-1 -: 8];
              r_shift    <= w_pc_al << 8;
              r_left     <= 8'(NB_PC/8 - 1);
              r_tx_valid <= 1'b1;
            end
            default: ;
          endcase
        end

        ST_LEN_HI: if (host.i_rx_valid) begin
          r_len[15:8] <= host.i_rx_data;
          r_state     <= ST_LEN_LO;
        end

        ST_LEN_LO: if (host.i_rx_valid) begin
          r_len <= w_len;
          r_cnt <= '0;
          if (w_len == 16'd0) begin
            r_state    <= ST_ACK;
            r_tx_data  <= 8'h4C;
            r_tx_valid <= 1'b1;
          end else begin
            r_state <= ST_LOAD;
          end
        end

        // Bytes beyond the memory capacity are consumed without a write.
        ST_LOAD: if (host.i_rx_valid) begin
          if (32'(r_cnt) < 32'(MAX_INSTR_BYTES)) begin
            r_im_we   <= 1'b1;
            r_im_addr <= NB_ADDR'(r_cnt);
            r_im_data <= host.i_rx_data;
          end
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == r_len - 16'd1) begin
            r_state    <= ST_ACK;
            r_tx_data  <= 8'h4C;
            r_tx_valid <= 1'b1;
          end
        end

        ST_ACK: if (host.i_tx_ready) begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end

        // One cycle with the pipeline held in reset; a halt here is ignored.
        ST_PRE_RUN: begin
          r_cycles     <= '0;
          r_pc_reset   <= 1'b0;
          r_pipe_reset <= 1'b0;
`ifdef STEP_MODE_EN
          r_fresh      <= 1'b0;
          if (r_go_step) begin
            r_state     <= ST_STEP;
            r_step_done <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_pc_enable <= 1'b1;
          end
`else
          r_state     <= ST_RUN;
          r_pc_enable <= 1'b1;
`endif
        end

        // RX bytes are dropped while running.
        ST_RUN: if (i_halt) begin
          r_pc_enable <= 1'b0;
          r_state     <= ST_DUMP_PC;
          r_tx_data   <= i_last_pc[NB_PC-1 -: 8];
          r_shift     <= w_pc_al << 8;
          r_left      <= 8'(NB_PC/8 - 1);
          r_tx_valid  <= 1'b1;
        end

`ifdef STEP_MODE_EN
        ST_STEP: begin
          if (!r_step_done) begin
            r_pc_enable <= !i_halt;
            r_step_done <= 1'b1;
          end else begin
            r_pc_enable <= 1'b0;
            r_state     <= ST_DUMP_PC;
            r_tx_data   <= i_last_pc[NB_PC-1 -: 8];
            r_shift     <= w_pc_al << 8;
            r_left      <= 8'(NB_PC/8 - 1);
            r_tx_valid  <= 1'b1;
          end
        end
`endif

        // PC then counter are streamed back to back with no gap.
        ST_DUMP_PC: if (w_slot) begin
          r_tx_valid <= 1'b1;
          if (r_left != 8'd0) begin
            r_tx_data <= r_shift[NB_SH-1 -: 8];
            r_shift   <= r_shift << 8;
            r_left    <= r_left - 8'd1;
          end else begin
            r_state   <= ST_DUMP_CYC;
            r_tx_data <= r_cycles[NB_CYCLES-1 -: 8];
            r_shift   <= w_cyc_al << 8;
            r_left    <= 8'(NB_CYCLES/8 - 1);
          end
        end

        ST_DUMP_CYC: if (w_slot) begin
          if (r_left != 8'd0) begin
            r_tx_data <= r_shift[NB_SH-1 -: 8];
            r_shift   <= r_shift << 8;
            r_left    <= r_left - 8'd1;
          end else begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_DUMP_REG;
            r_phase    <= 2'd0;
            r_idx      <= '0;
            r_reg_re   <= 1'b1;
            r_reg_addr <= '0;
          end
        end

        // Strobe, capture (first byte presented at once), then shift out.
        ST_DUMP_REG: case (r_phase)
          2'd0: begin
            r_reg_re <= 1'b0;
            r_phase  <= 2'd1;
          end
          2'd1: begin
            r_tx_data  <= i_bank_register_data[NB_DATA-1 -: 8];
            r_shift    <= w_reg_al << 8;
            r_left     <= 8'(NB_DATA/8 - 1);
            r_tx_valid <= 1'b1;
            r_phase    <= 2'd2;
          end
          default: if (w_slot) begin
            if (r_left != 8'd0) begin
              r_tx_data <= r_shift[NB_SH-1 -: 8];
              r_shift   <= r_shift << 8;
              r_left    <= r_left - 8'd1;
            end else begin
              r_tx_valid <= 1'b0;
              r_phase    <= 2'd0;
              if (r_idx == 16'(N_REGS - 1)) begin
                r_state    <= ST_DUMP_MEM;
                r_idx      <= '0;
                r_mem_re   <= 1'b1;
                r_mem_addr <= '0;
              end else begin
                r_idx      <= r_idx + 16'd1;
                r_reg_re   <= 1'b1;
                r_reg_addr <= NB_REG'(r_idx + 16'd1);
              end
            end
          end
        endcase

        // Resets are left untouched on exit so the pipeline state survives.
        ST_DUMP_MEM: case (r_phase)
          2'd0: begin
            r_mem_re <= 1'b0;
            r_phase  <= 2'd1;
          end
          2'd1: begin
            r_tx_data  <= i_mem_data_data;
            r_tx_valid <= 1'b1;
            r_phase    <= 2'd2;
          end
          default: if (w_slot) begin
            r_tx_valid <= 1'b0;
            r_phase    <= 2'd0;
            if (r_idx == 16'(N_MEM_BYTES - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx      <= r_idx + 16'd1;
              r_mem_re   <= 1'b1;
              r_mem_addr <= NB_MEM_ADDR'(r_idx + 16'd1);
            end
          end
        endcase

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host.o_tx_data              = r_tx_data;
  assign host.o_tx_valid             = r_tx_valid;
  assign o_pc_enable                 = r_pc_enable;
  assign o_pc_reset                  = r_pc_reset;
  assign o_pipeline_reset            = r_pipe_reset;
  assign o_instru_mem_write_enable   = r_im_we;
  assign o_instru_mem_addr           = r_im_addr;
  assign o_instru_mem_data           = r_im_data;
  assign o_bank_register_read_enable = r_reg_re;
  assign o_bank_register_addr        = r_reg_addr;
  assign o_mem_data_read_enable      = r_mem_re;
  assign o_mem_data_read_addr        = r_mem_addr;
  assign o_state                     = r_state;
endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Scoreboard bench for debug_unit_ctrl. Expected TX bytes and instruction
// writes are queued when stimulus is issued; monitors pop and compare.
module tb_debug_unit_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en, pc_rst, pipe_rst, im_we, reg_re, mem_re, halt;
  logic [31:0] im_addr, reg_data, last_pc;
  logic [7:0]  im_data, mem_data;
  logic [4:0]  reg_addr;
  logic [6:0]  mem_addr;
  logic [3:0]  state;

  debug_unit_ctrl_if ifc();

  debug_unit_ctrl dut (
    .i_clock(clk), .i_reset(rst), .host(ifc),
    .o_pc_enable(pc_en), .o_pc_reset(pc_rst), .o_pipeline_reset(pipe_rst),
    .o_instru_mem_write_enable(im_we), .o_instru_mem_addr(im_addr),
    .o_instru_mem_data(im_data),
    .o_bank_register_read_enable(reg_re), .o_bank_register_addr(reg_addr),
    .i_bank_register_data(reg_data),
    .o_mem_data_read_enable(mem_re), .o_mem_data_read_addr(mem_addr),
    .i_mem_data_data(mem_data),
    .i_halt(halt), .i_last_pc(last_pc), .o_state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_tx = 0, en_total = 0;
  logic [7:0]  txq[$];
  logic [39:0] wq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  function automatic logic [31:0] rv(input int r);
    return {8'(r), 8'h11, 8'(r * 3), 8'hC0};
  endfunction
  function automatic logic [7:0] mv(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    for (int i = 3; i >= 0; i--) txq.push_back(pc[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) txq.push_back(cyc[i*8 +: 8]);
    for (int r = 0; r < 32; r++) begin
      logic [31:0] w;
      w = rv(r);
      for (int i = 3; i >= 0; i--) txq.push_back(w[i*8 +: 8]);
    end
    for (int a = 0; a < 128; a++) txq.push_back(mv(a));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.i_rx_data  = b;
    ifc.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc.i_rx_valid = 1'b0;
  endtask

  // Wait until both queues drain and the FSM is back in IDLE.
  task automatic wait_done(input string nm, input int stall_at);
    bit ok = 0, stalled = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && !stalled && n_tx >= stall_at) begin
        ifc.i_tx_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 ifc.i_tx_ready = 1'b1;
        stalled = 1;
      end
      if (txq.size() == 0 && wq.size() == 0 && state == 4'd0 && !ifc.o_tx_valid) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  // Environment: register bank and data memory answer one cycle after strobe.
  initial forever begin
    @(negedge clk);
    if (reg_re) reg_data = rv(int'(reg_addr));
    if (mem_re) mem_data = mv(int'(mem_addr));
    if (pc_en)  en_total++;
  end

  // TX monitor: scoreboard pop on transfer, data hold under backpressure.
  logic       prev_v = 1'b0, prev_r = 1'b1;
  logic [7:0] prev_d = '0;
  initial forever begin
    @(negedge clk);
    if (prev_v && !prev_r)
      chk("tx_hold", 64'({ifc.o_tx_valid, ifc.o_tx_data}), 64'({1'b1, prev_d}));
    if (ifc.o_tx_valid && ifc.i_tx_ready) begin
      n_tx++;
      if (txq.size() == 0) flag("tx_unexpected", 64'(ifc.o_tx_data));
      else chk("tx_byte", 64'(ifc.o_tx_data), 64'(txq.pop_front()));
    end
    prev_v = ifc.o_tx_valid;
    prev_r = ifc.i_tx_ready;
    prev_d = ifc.o_tx_data;
  end

  // Instruction-write monitor.
  initial forever begin
    @(negedge clk);
    if (im_we) begin
      if (wq.size() == 0) flag("im_write_unexpected", 64'({im_addr, im_data}));
      else chk("im_write", 64'({im_addr, im_data}), 64'(wq.pop_front()));
    end
  end

  initial begin
    int t0;
    ifc.i_rx_data  = '0;
    ifc.i_rx_valid = 1'b0;
    ifc.i_tx_ready = 1'b1;
    halt     = 1'b0;
    last_pc  = 32'h0;
    reg_data = '0;
    mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_reset", 64'(pc_rst), 64'd1);
    chk("rst_pipe_reset", 64'(pipe_rst), 64'd1);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs", 64'({pc_en, ifc.o_tx_valid, im_we, reg_re, mem_re}), 64'd0);
    rst = 1'b0;

    // Load 4 bytes.
    wq.push_back({32'd0, 8'hDE}); wq.push_back({32'd1, 8'hAD});
    wq.push_back({32'd2, 8'hBE}); wq.push_back({32'd3, 8'hEF});
    txq.push_back(8'h4C);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_done("load4_done", -1);
    chk("load4_pc_reset", 64'(pc_rst), 64'd1);

    // Zero-length load acknowledges at once.
    txq.push_back(8'h4C);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    wait_done("load0_done", -1);

`ifndef STEP_MODE_EN
    // Without step mode 'S' is an unknown command.
    send_byte(8'h53);
    repeat (2) @(posedge clk);
    #1 chk("s_ignored", 64'(state), 64'd0);
`endif

    // Oversize load: 257 bytes, only the first 256 written.
    for (int k = 0; k < 256; k++) wq.push_back({32'(k), 8'(k) ^ 8'h5A});
    txq.push_back(8'h4C);
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'h01);
    for (int k = 0; k < 257; k++) send_byte(8'(k) ^ 8'h5A);
    wait_done("load257_done", -1);

    // Continuous run; HALT raised after 5 enabled cycles, PC 0x14.
    last_pc = 32'h14;
    push_dump(32'h14, 32'd5);
    send_byte(8'h43);
    chk("prerun_state", 64'(state), 64'd5);
    chk("prerun_resets", 64'({pc_rst, pipe_rst, pc_en}), 64'b110);
    begin
      int en = 0;
      for (int c = 0; c < 50 && en < 5; c++) begin
        @(negedge clk);
        if (pc_en) en++;
      end
      chk("run_enabled", 64'(en), 64'd5);
    end
    halt = 1'b1;
    t0 = n_tx;
    @(negedge clk);
    chk("halt_resp_en", 64'(pc_en), 64'd0);
    chk("halt_resp_state", 64'(state), 64'd8);
    chk("run_resets_low", 64'({pc_rst, pipe_rst}), 64'd0);
    halt = 1'b0;
    wait_done("run_dump_done", t0 + 50);
    chk("run_dump_bytes", 64'(n_tx - t0), 64'd264);

    // Reset in the middle of a run.
    send_byte(8'h43);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_en", 64'(pc_en), 64'd0);
    chk("midrst_pc_reset", 64'(pc_rst), 64'd1);
    chk("midrst_tx_valid", 64'(ifc.o_tx_valid), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    push_dump(32'h14, 32'd0);
    send_byte(8'h44);
    wait_done("dcmd_dump_done", -1);

`ifdef STEP_MODE_EN
    // Three single steps after a load: counters 1, 2, 3.
    last_pc = 32'h20;
    wq.push_back({32'd0, 8'h00});
    txq.push_back(8'h4C);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    wait_done("step_load_done", -1);
    for (int s = 1; s <= 3; s++) begin
      int e0;
      e0 = en_total;
      push_dump(32'h20, 32'(s));
      send_byte(8'h53);
      wait_done("step_dump_done", -1);
      chk("step_pulse_cycles", 64'(en_total - e0), 64'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
